// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// sign fixup in a dedicated state, short path for divide-by-zero and overflow.
module muldiv_unit #(
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Start,
  input  logic [2:0]   Funct3,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic         Flush,
  output logic         StallE,
  output logic         Busy,
  output logic         Done,
  output logic [M-1:0] Result
);

  localparam int unsigned CW = $clog2(M);
  localparam int unsigned W2 = 2 * M;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t         state, state_n;
  logic [2:0]     op;
  logic           neg;
  logic [CW-1:0]  count;
  logic [M-1:0]   mag;   // multiplicand (multiply) or divisor magnitude (divide)
  logic [W2-1:0]  acc;   // multiply: {partial product, multiplier}; divide: low half is dividend/quotient
  logic [M-1:0]   rem;

  // Acceptance-time operand decode
  logic           accept_c, sgn_a_c, sgn_b_c, a_neg_c, b_neg_c, neg_in_c;
  logic           is_div_c, is_rem_c, div0_c, ovf_c, special_c;
  logic [M-1:0]   abs_a_c, abs_b_c, special_val_c, min_neg_c;

  always_comb begin
    accept_c      = (state == IDLE) && Start && !Flush;
    sgn_a_c       = (Funct3 == F_MULH) || (Funct3 == F_MULHSU) ||
                    (Funct3 == F_DIV)  || (Funct3 == F_REM);
    sgn_b_c       = (Funct3 == F_MULH) || (Funct3 == F_DIV) || (Funct3 == F_REM);
    a_neg_c       = sgn_a_c && A[M-1];
    b_neg_c       = sgn_b_c && B[M-1];
    abs_a_c       = a_neg_c ? (~A + M'(1)) : A;
    abs_b_c       = b_neg_c ? (~B + M'(1)) : B;
    is_div_c      = Funct3[2];
    is_rem_c      = Funct3[2] && Funct3[1];
    neg_in_c      = is_rem_c ? a_neg_c : (a_neg_c ^ b_neg_c);
    min_neg_c     = {1'b1, {(M-1){1'b0}}};
    div0_c        = is_div_c && (B == '0);
    ovf_c         = is_div_c && !Funct3[0] && (A == min_neg_c) && (B == '1);
    special_c     = div0_c || ovf_c;
    special_val_c = '0;
    if (div0_c) special_val_c = is_rem_c ? A : '1;
    else        special_val_c = is_rem_c ? '0 : min_neg_c;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [M:0]     sum_c, trial_c, diff_c;
  logic           ge_c;

  always_comb begin
    sum_c   = {1'b0, acc[W2-1:M]} + (acc[0] ? {1'b0, mag} : '0);
    trial_c = {rem, acc[M-1]};
    diff_c  = trial_c - {1'b0, mag};
    ge_c    = (trial_c >= {1'b0, mag});
  end

  // Sign correction and result selection for FIXUP
  logic [W2-1:0]  prod_s_c;
  logic [M-1:0]   quot_s_c, rem_s_c, fix_val_c;

  always_comb begin
    prod_s_c  = neg ? (~acc + W2'(1)) : acc;
    quot_s_c  = neg ? (~acc[M-1:0] + M'(1)) : acc[M-1:0];
    rem_s_c   = neg ? (~rem + M'(1)) : rem;
    fix_val_c = prod_s_c[M-1:0];
    case (op)
      F_MUL:                  fix_val_c = prod_s_c[M-1:0];
      3'b001, 3'b010, 3'b011: fix_val_c = prod_s_c[W2-1:M];
      3'b100, 3'b101:         fix_val_c = quot_s_c;
      default:                fix_val_c = rem_s_c;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; Flush returns to IDLE from anywhere
  always_comb begin
    state_n = state;
    if (Flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (Start) state_n = special_c ? DONE : CALC;
        CALC:    if (count == CW'(M - 1)) state_n = FIXUP;
        FIXUP:   state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Stall covers the accepting cycle and all working cycles, released in DONE
  assign StallE = accept_c || (state == CALC) || (state == FIXUP);

  // Datapath, result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      neg    <= 1'b0;
      count  <= '0;
      mag    <= '0;
      acc    <= '0;
      rem    <= '0;
      Result <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      Done <= (state_n == DONE);
      Busy <= (state_n != IDLE);
      if (accept_c) begin
        op    <= Funct3;
        neg   <= neg_in_c;
        count <= '0;
        rem   <= '0;
        if (is_div_c) begin
          mag <= abs_b_c;
          acc <= {{M{1'b0}}, abs_a_c};
        end else begin
          mag <= abs_a_c;
          acc <= {{M{1'b0}}, abs_b_c};
        end
        if (special_c) Result <= special_val_c;
      end else if (state == CALC) begin
        count <= count + CW'(1);
        if (op[2]) begin
          rem         <= M'(ge_c ? diff_c : trial_c);
          acc[M-1:0]  <= {acc[M-2:0], ge_c};
        end else begin
          acc <= {sum_c, acc[M-1:1]};
        end
      end else if ((state == FIXUP) && !Flush) begin
        Result <= fix_val_c;
      end
    end
  end

endmodule
